// File: rtl/llbit_resv.sv
// llbit_resv: LL/SC reservation holder. Owns the architectural LLbit and the
// reserved word address; LL sets it, snoops/flushes/SC clear it, and SC
// verdicts are returned through a ready/valid handshake.
// Optional feature macro: LLBIT_TIMEOUT_EN (reservation auto-expires after
// 2^TIMEOUT_W - 1 cycles in RESV).
module llbit_resv #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ll_wb_valid,
  input  logic [ADDR_W-1:0] ll_wb_addr,
  input  logic              flush,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              sc_req,
  input  logic [ADDR_W-1:0] sc_addr,
  output logic              sc_ready,
  output logic              sc_resp_valid,
  output logic              sc_success,
  output logic              llbit_o
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    RESV    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] resv_addr;
  logic              sc_acc;
  logic              sc_ok;
  logic              snoop_hit;
  logic              timeout_hit;

`ifdef LLBIT_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;

  // Reservation age: restarts on a fresh LL or whenever RESV is left
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if ((state_next != RESV) || (ll_wb_valid && !flush)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
    end
  end

  assign timeout_hit = (state == RESV) && (tmo_cnt == {TIMEOUT_W{1'b1}});
`else
  logic [TIMEOUT_W-1:0] unused_timeout;
  assign unused_timeout = '0;
  assign timeout_hit    = 1'b0;
`endif

  // Byte-offset bits never take part in word compares
  logic unused_lsbs;
  assign unused_lsbs = ^{sc_addr[1:0], snoop_addr[1:0], resv_addr[1:0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Handshake and verdict decode; snoops compare against the pre-edge address
  always_comb begin
    sc_ready  = (state != RESOLVE) && !ll_wb_valid && !flush;
    sc_acc    = sc_req && sc_ready;
    snoop_hit = (state == RESV) && snoop_valid &&
                (snoop_addr[ADDR_W-1:2] == resv_addr[ADDR_W-1:2]);
    sc_ok     = (state == RESV) && !snoop_hit &&
                (sc_addr[ADDR_W-1:2] == resv_addr[ADDR_W-1:2]);
  end

  // Next state: flush > LL > SC accept > snoop hit / timeout
  always_comb begin
    state_next = state;
    unique case (state)
      RESOLVE: begin
        if (flush) begin
          state_next = EMPTY;
        end else if (ll_wb_valid) begin
          state_next = RESV;
        end else begin
          state_next = EMPTY;
        end
      end
      EMPTY, RESV: begin
        if (flush) begin
          state_next = EMPTY;
        end else if (ll_wb_valid) begin
          state_next = RESV;
        end else if (sc_acc) begin
          state_next = RESOLVE;
        end else if (snoop_hit || timeout_hit) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Registered outputs and the reserved address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      llbit_o       <= 1'b0;
      sc_resp_valid <= 1'b0;
      sc_success    <= 1'b0;
      resv_addr     <= '0;
    end else begin
      llbit_o       <= (state_next == RESV);
      sc_resp_valid <= sc_acc;
      if (sc_acc) begin
        sc_success <= sc_ok;
      end
      if (ll_wb_valid && !flush) begin
        resv_addr <= ll_wb_addr;
      end
    end
  end

endmodule

// File: tb/tb_llbit_resv.sv
// tb_llbit_resv: directed stimulus with a verdict scoreboard. Expected SC
// verdicts are queued when a request is issued; a monitor pops and compares
// on every sc_resp_valid pulse.
module tb_llbit_resv;

  localparam int unsigned AW = 32;
  localparam int unsigned TW = 4;
`ifdef LLBIT_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ll_wb_valid;
  logic [AW-1:0] ll_wb_addr;
  logic          flush;
  logic          snoop_valid;
  logic [AW-1:0] snoop_addr;
  logic          sc_req;
  logic [AW-1:0] sc_addr;
  logic          sc_ready;
  logic          sc_resp_valid;
  logic          sc_success;
  logic          llbit_o;

  int passed = 0;
  int total  = 0;
  bit exp_q[$];

  llbit_resv #(.ADDR_W(AW), .TIMEOUT_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ll_wb_valid  (ll_wb_valid),
    .ll_wb_addr   (ll_wb_addr),
    .flush        (flush),
    .snoop_valid  (snoop_valid),
    .snoop_addr   (snoop_addr),
    .sc_req       (sc_req),
    .sc_addr      (sc_addr),
    .sc_ready     (sc_ready),
    .sc_resp_valid(sc_resp_valid),
    .sc_success   (sc_success),
    .llbit_o      (llbit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_in();
    ll_wb_valid = 1'b0; ll_wb_addr = '0; flush = 1'b0;
    snoop_valid = 1'b0; snoop_addr = '0; sc_req = 1'b0; sc_addr = '0;
  endtask

  task automatic do_ll(input logic [AW-1:0] a);
    idle_in(); ll_wb_valid = 1'b1; ll_wb_addr = a;
    tick();
    idle_in();
  endtask

  // Issue an SC expected to be accepted at the next edge
  task automatic do_sc(input logic [AW-1:0] a, input bit exp_ok);
    sc_req = 1'b1; sc_addr = a;
    exp_q.push_back(exp_ok);
    tick();
    sc_req = 1'b0;
  endtask

  // Verdict monitor
  always @(negedge clk) begin
    if (!rst && sc_resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_verdict", 32'(sc_resp_valid), 32'd0);
      end else begin
        bit e;
        e = exp_q.pop_front();
        chk("sc_success", 32'(sc_success), 32'(e));
      end
    end
  end

  initial begin
    idle_in();
    rst = 1'b1;
    tick(); tick();
    chk("rst_llbit", 32'(llbit_o), 32'd0);
    chk("rst_valid", 32'(sc_resp_valid), 32'd0);
    chk("rst_success", 32'(sc_success), 32'd0);
    chk("rst_ready", 32'(sc_ready), 32'd1);
    rst = 1'b0;
    tick();

    // LL then SC same address two cycles later: pass
    do_ll(32'h1000);
    chk("t1_llbit_set", 32'(llbit_o), 32'd1);
    tick();
    sc_req = 1'b1; sc_addr = 32'h1000; #1;
    chk("t1_ready", 32'(sc_ready), 32'd1);
    exp_q.push_back(1'b1);
    tick();
    sc_req = 1'b0; #1;
    chk("t1_resolve_ready", 32'(sc_ready), 32'd0);
    chk("t1_resolve_llbit", 32'(llbit_o), 32'd0);
    tick();
    chk("t1_after_llbit", 32'(llbit_o), 32'd0);

    // Snoop on same word clears; SC fails
    do_ll(32'h1000);
    snoop_valid = 1'b1; snoop_addr = 32'h1002;
    tick();
    idle_in();
    chk("t2_snoop_clear", 32'(llbit_o), 32'd0);
    do_sc(32'h1000, 1'b0);
    tick();

    // LL and matching snoop same cycle: reservation survives
    idle_in(); ll_wb_valid = 1'b1; ll_wb_addr = 32'h1000;
    snoop_valid = 1'b1; snoop_addr = 32'h1000;
    tick();
    idle_in();
    chk("t3_llbit_held", 32'(llbit_o), 32'd1);
    do_sc(32'h1000, 1'b1);
    tick();

    // SC to another word fails and consumes the reservation
    do_ll(32'h1000);
    do_sc(32'h2000, 1'b0);
    tick();
    chk("t4_consumed", 32'(llbit_o), 32'd0);

    // Flush in RESV clears
    do_ll(32'h1000);
    flush = 1'b1;
    tick();
    idle_in();
    chk("t5_flush_clear", 32'(llbit_o), 32'd0);

    // Flush during RESOLVE: verdict still delivered, ends EMPTY
    do_ll(32'h1000);
    do_sc(32'h1000, 1'b1);
    flush = 1'b1;
    tick();
    idle_in(); #1;
    chk("t5_after_flush_llbit", 32'(llbit_o), 32'd0);
    chk("t5_after_flush_ready", 32'(sc_ready), 32'd1);

    // LL with SC pending: not accepted that cycle, accepted next
    idle_in(); ll_wb_valid = 1'b1; ll_wb_addr = 32'h1000;
    sc_req = 1'b1; sc_addr = 32'h1000; #1;
    chk("t6_ready_ll", 32'(sc_ready), 32'd0);
    tick();
    ll_wb_valid = 1'b0; #1;
    chk("t6_llbit", 32'(llbit_o), 32'd1);
    chk("t6_ready_after", 32'(sc_ready), 32'd1);
    exp_q.push_back(1'b1);
    tick();
    sc_req = 1'b0;
    tick();

    // SC held in EMPTY back-to-back: fail, not ready in RESOLVE, re-accepted N+2
    sc_req = 1'b1; sc_addr = 32'h1000;
    exp_q.push_back(1'b0);
    tick();
    #1;
    chk("t7_ready_resolve", 32'(sc_ready), 32'd0);
    exp_q.push_back(1'b0);
    tick();
    #1;
    chk("t7_ready_again", 32'(sc_ready), 32'd1);
    tick();
    sc_req = 1'b0;
    tick();

    // Other-word snoop keeps reservation; SC with same-cycle matching snoop fails
    do_ll(32'h1000);
    snoop_valid = 1'b1; snoop_addr = 32'h1004;
    tick();
    idle_in();
    chk("t8_other_word", 32'(llbit_o), 32'd1);
    snoop_valid = 1'b1; snoop_addr = 32'h1000;
    do_sc(32'h1003, 1'b0);
    idle_in();
    tick();

    // Reset during RESOLVE drops the verdict
    do_ll(32'h1000);
    sc_req = 1'b1; sc_addr = 32'h1000;
    @(posedge clk); #1;
    rst = 1'b1; sc_req = 1'b0;
    tick();
    chk("t9_rst_valid", 32'(sc_resp_valid), 32'd0);
    chk("t9_rst_llbit", 32'(llbit_o), 32'd0);
    rst = 1'b0;
    tick();

    // Long idle after LL: expires only with the timeout feature
    do_ll(32'h1000);
    repeat (20) tick();
    chk("t10_idle_llbit", 32'(llbit_o), TMO ? 32'd0 : 32'd1);
    do_sc(32'h1000, !TMO);
    tick(); tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/llbit_resv.md
# llbit_resv

LL/SC reservation holder for the MIPS core: owns the architectural LLbit and the reserved word address. A retiring LL sets the reservation, and snoops or flushes clear it. Store-conditional requests get a pass/fail verdict through a ready/valid handshake. It is the write/owner side of the LLbit whose in-flight writes the pipeline's outstanding-write tracker counts; `llbit_o` is the value the pipeline reads once that tracker reports no pending write.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width; compares use bits `[ADDR_W-1:2]` (word granularity).
- `TIMEOUT_W`, 8, width of the reservation timeout counter (used only with `LLBIT_TIMEOUT_EN`).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `ll_wb_valid`  in  1  LL retiring in WB this cycle.
- `ll_wb_addr`  in  ADDR_W  LL effective address.
- `flush`  in  1  exception/ERET; kills the reservation.
- `snoop_valid`  in  1  store (any master) committing this cycle.
- `snoop_addr`  in  ADDR_W  snooped store address.
- `sc_req`  in  1  SC requests a verdict; held until accepted.
- `sc_addr`  in  ADDR_W  SC effective address; stable while `sc_req` is high.
- `sc_ready`  out  1  SC is accepted on `sc_req & sc_ready`.
- `sc_resp_valid`  out  1  verdict valid, one-cycle pulse.
- `sc_success`  out  1  verdict; meaningful only with `sc_resp_valid`.
- `llbit_o`  out  1  current LLbit, registered.

## Operation
FSM states:
- `EMPTY`: no reservation.
- `RESV`: reservation held on `resv_addr`.
- `RESOLVE`: one-cycle state that drives the verdict.

`sc_ready = (state != RESOLVE) & ~ll_wb_valid & ~flush`. This is combinational, and an SC is never accepted in the same cycle as an LL or a flush.

Per-cycle priority, highest first:
1. `flush`: state goes to `EMPTY`, except from `RESOLVE`, where the pending verdict is still delivered and the state then goes to `EMPTY`.
2. `ll_wb_valid`:
   - `resv_addr <= ll_wb_addr`; state goes to `RESV` from `EMPTY` or `RESV`.
   - From `RESOLVE`, the verdict completes and the state then goes to `RESV` with the new address.
3. SC accept: `sc_ok = (state==RESV) & (sc_addr[ADDR_W-1:2]==resv_addr[ADDR_W-1:2]) & ~snoop_hit`. Register `sc_ok` into `sc_success`; state goes to `RESOLVE`.
4. Snoop hit in `RESV` (`snoop_valid` and word-address match with `resv_addr`): state goes to `EMPTY`.

Other rules:
- A snoop is always compared against `resv_addr` as it stood before the edge. A snoop in the same cycle as an LL does not clear the new reservation.
- Leaving `RESOLVE` goes to `EMPTY`, because an SC always consumes the reservation, whether it passed or failed.
- A failing SC while in `EMPTY` is legal and returns `sc_success=0`.
- `llbit_o` is 1 exactly when the registered state is `RESV`.
- `resv_addr` keeps its value when cleared; only `llbit_o` and the state carry meaning.

## Timing
- Reset values: state `EMPTY`, `llbit_o=0`, `sc_resp_valid=0`, `sc_success=0`, `resv_addr=0`, timeout counter 0. With all inputs low, `sc_ready=1`.
- LL at cycle N: `llbit_o=1` from cycle N+1.
- SC accepted at cycle N: `sc_resp_valid=1` with `sc_success` at N+1 only. `sc_ready=0` at N+1. Earliest next accept is N+2.
- Snoop or flush at cycle N: `llbit_o=0` at N+1.
- Reset asserted mid-SC: the verdict is dropped and there is no `sc_resp_valid` pulse.

## Configuration
- `LLBIT_TIMEOUT_EN` defined:
  - A `TIMEOUT_W`-bit counter runs while in `RESV`, and is cleared whenever an LL sets `RESV` or the state leaves `RESV`.
  - When it reaches `2^TIMEOUT_W - 1`, the state goes to `EMPTY` on the next edge. This has the same priority as a snoop hit.
  - An SC accepted in that same cycle still sees `RESV` and can pass.
- Not defined: no counter is built, and a reservation persists until it is cleared by flush, snoop or SC.

## Test plan
- LL at `0x1000`, then SC at `0x1000` two cycles later: `llbit_o` rises the cycle after the LL; the verdict pulse has `sc_success=1`; `llbit_o=0` after `RESOLVE`.
- LL at `0x1000`, snoop at `0x1002` (same word), then SC at `0x1000`: `llbit_o` drops the cycle after the snoop; `sc_success=0`.
- LL at `0x1000` and snoop at `0x1000` in the same cycle: reservation held (`llbit_o=1`); a later SC at `0x1000` passes.
- LL at `0x1000`, then SC at `0x2000`: `sc_success=0`, and the reservation is consumed (`llbit_o=0`).
- SC accepted, then `flush` during `RESOLVE`: `sc_resp_valid` still pulses with the registered verdict; state ends `EMPTY`. Separately, `ll_wb_valid` high with `sc_req` high gives `sc_ready=0` and no accept.
- With `LLBIT_TIMEOUT_EN` and `TIMEOUT_W=4`: LL, then idle 15 cycles: `llbit_o=0`; a subsequent SC fails.
